// File: rtl/mem_pkg.sv
// Shared definitions for the banked main-memory responder: bank geometry,
// default timing and the address split helpers.
package mem_pkg;

    localparam int NUM_BANKS       = 4;
    localparam int BANK_SEL_LSB    = 1;
    localparam int BANK_SEL_W      = 2;
    localparam int ROW_LSB         = BANK_SEL_LSB + BANK_SEL_W;
    localparam int DEF_BANK_CYCLES = 4;
    localparam int DEF_READ_LAT    = 2;
    localparam int BANK_CNT_W      = 4;   // holds BANK_CYCLES-1 for BANK_CYCLES up to 15
    localparam int ADDR_MAX_W      = 32;  // widest byte address the helpers accept

    typedef logic [ADDR_MAX_W-1:0] addr_t;

    // Word-interleaved bank select: consecutive 16-bit words land in consecutive banks.
    function automatic logic [BANK_SEL_W-1:0] bank_of(input addr_t a);
        return a[BANK_SEL_LSB +: BANK_SEL_W];
    endfunction

    // Row inside the selected bank; callers truncate to their own row width.
    function automatic logic [ADDR_MAX_W-ROW_LSB-1:0] row_of(input addr_t a);
        return a[ADDR_MAX_W-1:ROW_LSB];
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One memory bank: storage array, occupancy down-counter and a write port
// plus an asynchronous read port (the caller samples it on the accept edge).
module mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ROW_W       = 13,
    parameter int DEPTH_WORDS = 8192,
    parameter int BANK_CYCLES = DEF_BANK_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc,
    input  logic              wr_en,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    logic [BANK_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]     mem [DEPTH_WORDS];

    // Occupancy counter: reload on accept, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (acc) begin
            cnt_d = BANK_CNT_W'(BANK_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - BANK_CNT_W'(1);
        end
    end

    // Counter register; reset clears any occupancy mid-access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (acc && wr_en) begin
            mem[row] <= wdata;
        end
    end

    assign rdata = mem[row];
    assign busy  = (cnt_q != '0);

endmodule

// File: rtl/banked_mem_resp.sv
// Four-bank word-interleaved memory responder: request decode, stall/err
// generation and the fixed-latency read-return pipeline.
// Optional build macro MEM_ALIGN_CHECK_EN: treat odd byte addresses as illegal
// requests (dropped with an err pulse). Without it addr[0] is ignored.
module banked_mem_resp
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = 8192,
    parameter int BANK_CYCLES = DEF_BANK_CYCLES,
    parameter int READ_LAT    = DEF_READ_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DATA_W-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);

    localparam int ROW_W = ADDR_W - ROW_LSB;

    addr_t                 addr_ext;
    logic [BANK_SEL_W-1:0] bank_sel;
    logic [ROW_W-1:0]      row;
    logic                  req, illegal, legal, accept;
    logic [NUM_BANKS-1:0]  bank_acc;
    logic [DATA_W-1:0]     bank_rdata [NUM_BANKS];
    logic [DATA_W-1:0]     rword;

    logic [READ_LAT-1:0]   vld_q, vld_d;
    logic [DATA_W-1:0]     data_q [READ_LAT];
    logic [DATA_W-1:0]     data_d [READ_LAT];
    logic                  err_q, err_d;

    assign addr_ext = addr_t'(addr);
    assign bank_sel = bank_of(addr_ext);
    assign row      = ROW_W'(row_of(addr_ext));

    // Request decode: legality, stall against the addressed bank, accept strobes.
    always_comb begin
        req     = wr | rd;
        illegal = wr & rd;
`ifdef MEM_ALIGN_CHECK_EN
        illegal = illegal | (req & addr[0]);
`endif
        legal    = req & ~illegal;
        stall    = legal & busy[bank_sel];
        accept   = legal & ~busy[bank_sel];
        err_d    = illegal;
        bank_acc = '0;
        bank_acc[bank_sel] = accept;
        rword    = bank_rdata[bank_sel];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .DATA_W      (DATA_W),
            .ROW_W       (ROW_W),
            .DEPTH_WORDS (DEPTH_WORDS),
            .BANK_CYCLES (BANK_CYCLES)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .acc   (bank_acc[b]),
            .wr_en (wr),
            .row   (row),
            .wdata (data_in),
            .rdata (bank_rdata[b]),
            .busy  (busy[b])
        );
    end

    // Read-return shift: stage 0 samples the array on the accept edge.
    always_comb begin
        vld_d[0]  = accept & rd;
        data_d[0] = rword;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
    end

    // Control registers: valid chain and err pulse, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
        end
    end

    // Data chain carries no reset; the output mask hides stale words.
    always_ff @(posedge clk) begin
        for (int i = 0; i < READ_LAT; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    assign rd_valid = vld_q[READ_LAT-1];
    assign data_out = vld_q[READ_LAT-1] ? data_q[READ_LAT-1] : '0;
    assign err      = err_q;

endmodule
